// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: carries BTB predictions IF->ID->EX, checks each one against the
// resolved outcome in EX, and drives the redirect PC, the IF/ID flush and branch statistics.
module branch_resolve_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             stall_i,
    input  logic [WIDTH-1:0] pc_IF_i,
    input  logic             br_sel_BTB_i,
    input  logic [WIDTH-1:0] btb_pc_i,
    input  logic [31:0]      instr_EX_i,
    input  logic [WIDTH-1:0] pc_EX_i,
    input  logic [WIDTH-1:0] alu_data_i,
    input  logic             taken_i,
    output logic [WIDTH-1:0] pc_next_o,
    output logic             flush_o,
    output logic [CNT_W-1:0] br_count_o,
    output logic [CNT_W-1:0] mispred_count_o
);

    typedef enum logic [4:0] {
        OP_BRANCH = 5'b11000,
        OP_JAL    = 5'b11011,
        OP_JALR   = 5'b11001
    } cti_op_e;

    typedef struct packed {
        logic             vld;
        logic             ptaken;
        logic [WIDTH-1:0] ptarget;
    } pred_t;

    pred_t            if_rec;
    pred_t            id_q;
    pred_t            ex_q;
    logic [4:0]       op_ex;
    logic             is_cti;
    logic             dir_wrong;
    logic             tgt_wrong;
    logic             mispredict;
    logic [WIDTH-1:0] pc_if_seq;
    logic [WIDTH-1:0] pc_ex_seq;
    logic             unused_instr_bits;

    // Only the major opcode matters for classifying a control transfer.
    assign op_ex             = instr_EX_i[6:2];
    assign unused_instr_bits = ^{instr_EX_i[31:7], instr_EX_i[1:0]};

    assign is_cti = (op_ex == OP_BRANCH) || (op_ex == OP_JAL) || (op_ex == OP_JALR);

    assign if_rec    = '{vld: 1'b1, ptaken: br_sel_BTB_i, ptarget: btb_pc_i};
    assign pc_if_seq = pc_IF_i + WIDTH'(4);
    assign pc_ex_seq = pc_EX_i + WIDTH'(4);

    // A non-CTI carrying a taken prediction is a BTB tag alias: its real path is pc+4.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        mispredict = 1'b0;
        dir_wrong  = ex_q.ptaken != taken_i;
        tgt_wrong  = taken_i && (ex_q.ptarget != alu_data_i);
        if (rst_ni && ex_q.vld) begin
            mispredict = is_cti ? (dir_wrong || tgt_wrong) : ex_q.ptaken;
        end
    end

    assign flush_o = mispredict;

    always_comb begin
        pc_next_o = pc_if_seq;
        if (!rst_ni) begin
            pc_next_o = '0;
        end else if (mispredict && taken_i && is_cti) begin
            pc_next_o = alu_data_i;
        end else if (mispredict) begin
            pc_next_o = pc_ex_seq;
        end else if (br_sel_BTB_i) begin
            pc_next_o = btb_pc_i;
        end
    end

    // Flush outranks stall: the killed ID/EX slots must not survive a held pipeline.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples
            // pre-edge values regardless of statement order.
            id_q <= '0;
            ex_q <= '0;
        end else if (flush_o) begin
            id_q.vld <= 1'b0;
            ex_q.vld <= 1'b0;
        end else if (stall_i) begin
            ex_q.vld <= 1'b0;
        end else begin
            id_q <= if_rec;
            ex_q <= id_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            br_count_o      <= '0;
            mispred_count_o <= '0;
        end else begin
            if (ex_q.vld && is_cti && (br_count_o != {CNT_W{1'b1}})) begin
                br_count_o <= br_count_o + CNT_W'(1);
            end
            if (mispredict && (mispred_count_o != {CNT_W{1'b1}})) begin
                mispred_count_o <= mispred_count_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed vectors push expected outputs,
// a negedge monitor pops and compares; a 2-bit-counter instance checks saturation.
module tb_branch_resolve_unit;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] ADDI = 32'h0010_0513;
    localparam logic [31:0] BEQ  = 32'h0000_0063;
    localparam logic [31:0] BNE  = 32'h0000_1063;
    localparam logic [31:0] JAL  = 32'h0000_006F;
    localparam logic [31:0] JALR = 32'h0000_0067;

    typedef struct packed {
        logic        flush;
        logic [31:0] pc;
        logic [31:0] br;
        logic [31:0] mp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        stall;
    logic [31:0] pc_if;
    logic        br_sel;
    logic [31:0] btb_pc;
    logic [31:0] instr_ex;
    logic [31:0] pc_ex;
    logic [31:0] alu_data;
    logic        taken;
    logic [31:0] pc_next;
    logic        flush;
    logic [31:0] br_count;
    logic [31:0] mispred_count;
    logic [31:0] pc_next_sat;
    logic        flush_sat;
    logic [1:0]  br_count_sat;
    logic [1:0]  mispred_count_sat;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    fails  = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.WIDTH(32), .CNT_W(32)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .stall_i         (stall),
        .pc_IF_i         (pc_if),
        .br_sel_BTB_i    (br_sel),
        .btb_pc_i        (btb_pc),
        .instr_EX_i      (instr_ex),
        .pc_EX_i         (pc_ex),
        .alu_data_i      (alu_data),
        .taken_i         (taken),
        .pc_next_o       (pc_next),
        .flush_o         (flush),
        .br_count_o      (br_count),
        .mispred_count_o (mispred_count)
    );

    branch_resolve_unit #(.WIDTH(32), .CNT_W(2)) dut_sat (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .stall_i         (stall),
        .pc_IF_i         (pc_if),
        .br_sel_BTB_i    (br_sel),
        .btb_pc_i        (btb_pc),
        .instr_EX_i      (instr_ex),
        .pc_EX_i         (pc_ex),
        .alu_data_i      (alu_data),
        .taken_i         (taken),
        .pc_next_o       (pc_next_sat),
        .flush_o         (flush_sat),
        .br_count_o      (br_count_sat),
        .mispred_count_o (mispred_count_sat)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    function automatic logic [31:0] sat3(input logic [31:0] v);
        return (v > 32'd3) ? 32'd3 : v;
    endfunction

    // Monitor: outputs are combinational each cycle, so one expectation per cycle is popped.
    always @(negedge clk) begin
        exp_t  e;
        string n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check({n, ".flush"},       {31'b0, flush},            {31'b0, e.flush});
            check({n, ".pc_next"},     pc_next,                   e.pc);
            check({n, ".br_count"},    br_count,                  e.br);
            check({n, ".mispred"},     mispred_count,             e.mp);
            check({n, ".br_sat"},      {30'b0, br_count_sat},     sat3(e.br));
            check({n, ".mispred_sat"}, {30'b0, mispred_count_sat}, sat3(e.mp));
        end
    end

    task automatic set_if(input logic [31:0] pc, input logic bs, input logic [31:0] tgt);
        pc_if  = pc;
        br_sel = bs;
        btb_pc = tgt;
    endtask

    task automatic set_ex(input logic [31:0] ins, input logic [31:0] pc,
                          input logic [31:0] alu, input logic tk);
        instr_ex = ins;
        pc_ex    = pc;
        alu_data = alu;
        taken    = tk;
    endtask

    task automatic step(input string name, input logic ef, input logic [31:0] epc,
                        input logic [31:0] ebr, input logic [31:0] emp);
        exp_t e;
        e.flush = ef;
        e.pc    = epc;
        e.br    = ebr;
        e.mp    = emp;
        exp_q.push_back(e);
        name_q.push_back(name);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        stall  = 1'b0;
        set_if(32'h1000, 1'b1, 32'hABC0);
        set_ex(BEQ, 32'h2000, 32'h3000, 1'b1);
        @(posedge clk);
        #1;

        // Reset holds outputs at zero even with redirect-looking inputs.
        step("rst0", 1'b0, 32'h0, 0, 0);
        step("rst1", 1'b0, 32'h0, 0, 0);
        rst_ni = 1'b1;
        set_if(32'h1000, 1'b0, 32'h0);
        set_ex(NOP, 32'h0, 32'h0, 1'b0);
        step("rst_release", 1'b0, 32'h1004, 0, 0);
        set_if(32'h1008, 1'b0, 32'h0); step("warm1", 1'b0, 32'h100C, 0, 0);
        set_if(32'h1010, 1'b0, 32'h0); step("warm2", 1'b0, 32'h1014, 0, 0);

        // Correctly predicted taken BEQ.
        set_if(32'h100, 1'b1, 32'h200); step("t2_if", 1'b0, 32'h200, 0, 0);
        set_if(32'h200, 1'b0, 32'h0);   step("t2_id", 1'b0, 32'h204, 0, 0);
        set_if(32'h204, 1'b0, 32'h0);
        set_ex(BEQ, 32'h100, 32'h200, 1'b1);
        step("t2_ex", 1'b0, 32'h208, 0, 0);

        // Predicted not-taken BNE resolves taken; next two EX slots are bubbles.
        set_if(32'h40, 1'b0, 32'h0);
        set_ex(NOP, 32'h0, 32'h0, 1'b0);
        step("t3_if", 1'b0, 32'h44, 1, 0);
        set_if(32'h44, 1'b0, 32'h0); step("t3_id", 1'b0, 32'h48, 1, 0);
        set_if(32'h48, 1'b1, 32'h999);
        set_ex(BNE, 32'h40, 32'h80, 1'b1);
        step("t3_ex", 1'b1, 32'h80, 1, 0);
        set_if(32'h80, 1'b0, 32'h0);
        set_ex(JAL, 32'h44, 32'h1234, 1'b1);
        step("t3_kill1", 1'b0, 32'h84, 2, 1);
        set_if(32'h84, 1'b0, 32'h0); step("t3_kill2", 1'b0, 32'h88, 2, 1);

        // JALR with the right direction but wrong target.
        set_if(32'h300, 1'b1, 32'h400);
        set_ex(NOP, 32'h0, 32'h0, 1'b0);
        step("t4_if", 1'b0, 32'h400, 2, 1);
        set_if(32'h400, 1'b0, 32'h0); step("t4_id", 1'b0, 32'h404, 2, 1);
        set_if(32'h404, 1'b0, 32'h0);
        set_ex(JALR, 32'h300, 32'h404, 1'b1);
        step("t4_ex", 1'b1, 32'h404, 2, 1);
        set_ex(NOP, 32'h0, 32'h0, 1'b0);
        set_if(32'h404, 1'b0, 32'h0); step("t4_kill1", 1'b0, 32'h408, 3, 2);
        set_if(32'h408, 1'b0, 32'h0); step("t4_kill2", 1'b0, 32'h40C, 3, 2);

        // BTB alias on an ADDI: redirect to pc+4 even though taken_i/alu look like a jump.
        set_if(32'h500, 1'b1, 32'h900); step("t5_if", 1'b0, 32'h900, 3, 2);
        set_if(32'h900, 1'b0, 32'h0);   step("t5_id", 1'b0, 32'h904, 3, 2);
        set_if(32'h904, 1'b0, 32'h0);
        set_ex(ADDI, 32'h500, 32'hDEAD0, 1'b1);
        step("t5_ex", 1'b1, 32'h504, 3, 2);
        set_ex(NOP, 32'h0, 32'h0, 1'b0);
        set_if(32'h504, 1'b0, 32'h0); step("t5_kill1", 1'b0, 32'h508, 3, 3);
        set_if(32'h508, 1'b0, 32'h0); step("t5_kill2", 1'b0, 32'h50C, 3, 3);

        // Stall together with a mispredict: flush wins and both slots are cleared.
        set_if(32'h600, 1'b0, 32'h0); step("t6_if", 1'b0, 32'h604, 3, 3);
        set_if(32'h604, 1'b0, 32'h0); step("t6_id", 1'b0, 32'h608, 3, 3);
        stall = 1'b1;
        set_if(32'h608, 1'b1, 32'hAAA);
        set_ex(BEQ, 32'h600, 32'h700, 1'b1);
        step("t6_stall_flush", 1'b1, 32'h700, 3, 3);
        stall = 1'b0;
        set_if(32'h700, 1'b0, 32'h0);
        set_ex(NOP, 32'h0, 32'h0, 1'b0);
        step("t6_after_flush", 1'b0, 32'h704, 4, 4);
        set_if(32'h704, 1'b1, 32'hC00);
        set_ex(JAL, 32'h608, 32'h777, 1'b1);
        step("t6_ex_bubble", 1'b0, 32'hC00, 4, 4);

        // Stall alone for two cycles: ID keeps the predicted JAL, EX bubbles ignore CTIs.
        stall = 1'b1;
        set_if(32'hC00, 1'b0, 32'h0);
        set_ex(NOP, 32'h0, 32'h0, 1'b0);
        step("t6_stall1", 1'b0, 32'hC04, 4, 4);
        set_ex(JAL, 32'h999, 32'h123, 1'b1);
        step("t6_stall2", 1'b0, 32'hC04, 4, 4);
        stall = 1'b0;
        set_ex(JAL, 32'h999, 32'h55, 1'b1);
        step("t6_unstall", 1'b0, 32'hC04, 4, 4);
        set_if(32'hC04, 1'b0, 32'h0);
        set_ex(JAL, 32'h704, 32'hC00, 1'b1);
        step("t6_held_ex", 1'b0, 32'hC08, 4, 4);

        // Sequential fetch wraps at the top of the address space.
        set_if(32'hFFFF_FFFC, 1'b0, 32'h0);
        set_ex(NOP, 32'h0, 32'h0, 1'b0);
        step("pc_wrap", 1'b0, 32'h0, 5, 4);

        // Reset asserted while an alias mispredict sits in EX drops the flush at once.
        set_if(32'h10, 1'b1, 32'h20); step("t7_if", 1'b0, 32'h20, 5, 4);
        set_if(32'h20, 1'b0, 32'h0);  step("t7_id", 1'b0, 32'h24, 5, 4);
        rst_ni = 1'b0;
        set_if(32'h24, 1'b0, 32'h0);
        set_ex(ADDI, 32'h10, 32'h0, 1'b0);
        step("rst_mid_flush", 1'b0, 32'h0, 0, 0);
        rst_ni = 1'b1;
        set_if(32'h30, 1'b0, 32'h0);
        set_ex(NOP, 32'h0, 32'h0, 1'b0);
        step("rst_release2", 1'b0, 32'h34, 0, 0);

        for (int i = 0; i < 8 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
